// File: rtl/localbus_matrix.sv
// localbus_matrix: decodes a single-master local bus onto NSLV slave windows.
// Each access is sequenced IDLE -> ACCESS -> RESP with a req/ready handshake.
// Unmapped accesses complete with err=1 straight from IDLE.
// Optional feature macro: LOCALBUS_MATRIX_TIMEOUT_EN adds an ACCESS timeout
// that forces an error response after TIMEOUT cycles without s_ready.
module localbus_matrix #(
    parameter int unsigned          XLEN      = 32,
    parameter int unsigned          NSLV      = 4,
    parameter logic [NSLV*XLEN-1:0] BASE_LIST = {NSLV*XLEN{1'b0}},
    parameter logic [NSLV*XLEN-1:0] MASK_LIST = {NSLV*XLEN{1'b0}},
    parameter int unsigned          TIMEOUT   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req,
    input  logic [XLEN-1:0]      addr,
    input  logic [XLEN-1:0]      qin,
    input  logic [2:0]           we,
    output logic                 busy,
    output logic                 ready,
    output logic                 err,
    output logic [XLEN-1:0]      qout,
    output logic [NSLV-1:0]      s_sel,
    output logic [XLEN-1:0]      s_addr,
    output logic [XLEN-1:0]      s_wdata,
    output logic [3*NSLV-1:0]    s_we,
    input  logic [XLEN*NSLV-1:0] s_qout,
    input  logic [NSLV-1:0]      s_ready
);

    // Reject configurations that cannot work rather than building them silently.
    if ((TIMEOUT < 2) || (NSLV < 1) || (NSLV > 16)) begin : g_param_check
        $error("localbus_matrix: NSLV must be 1..16 and TIMEOUT >= 2");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t              state_r, state_s;
    logic                busy_r, busy_s;
    logic                ready_r, ready_s;
    logic                err_r, err_s;
    logic [XLEN-1:0]     qout_r, qout_s;
    logic [NSLV-1:0]     sel_r, sel_s;
    logic [XLEN-1:0]     s_addr_r, s_addr_s;
    logic [XLEN-1:0]     s_wdata_r, s_wdata_s;
    logic [3*NSLV-1:0]   s_we_r, s_we_s;
    logic [2:0]          we_r, we_s;

    logic                dec_hit_s;
    logic [NSLV-1:0]     dec_sel_s;
    logic [XLEN-1:0]     dec_mask_s;
    logic [3*NSLV-1:0]   we_vec_s;
    logic [XLEN-1:0]     rd_data_s;
    logic                slv_rdy_s;

`ifdef LOCALBUS_MATRIX_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT);
    logic [CNT_W-1:0]    cnt_r, cnt_s;
`endif

    // Window decode on the live request: the lowest matching index wins overlaps.
    always_comb begin
        dec_hit_s  = 1'b0;
        dec_sel_s  = {NSLV{1'b0}};
        dec_mask_s = {XLEN{1'b0}};
        we_vec_s   = {(3*NSLV){1'b0}};
        for (int i = 0; i < NSLV; i++) begin
            if (!dec_hit_s && ((addr & MASK_LIST[i*XLEN +: XLEN]) == BASE_LIST[i*XLEN +: XLEN])) begin
                dec_hit_s         = 1'b1;
                dec_sel_s[i]      = 1'b1;
                dec_mask_s        = MASK_LIST[i*XLEN +: XLEN];
                we_vec_s[3*i +: 3] = we;
            end else begin
                dec_hit_s = dec_hit_s;
            end
        end
    end

    // Read-data mux and completion detect, restricted to the selected slot.
    always_comb begin
        rd_data_s = {XLEN{1'b0}};
        for (int i = 0; i < NSLV; i++) begin
            if (sel_r[i]) begin
                rd_data_s = rd_data_s | s_qout[i*XLEN +: XLEN];
            end else begin
                rd_data_s = rd_data_s;
            end
        end
        slv_rdy_s = |(s_ready & sel_r);
    end

    // Next-state and next-output logic for the access sequencer.
    always_comb begin
        state_s   = state_r;
        busy_s    = busy_r;
        ready_s   = 1'b0;
        err_s     = err_r;
        qout_s    = qout_r;
        sel_s     = sel_r;
        s_addr_s  = s_addr_r;
        s_wdata_s = s_wdata_r;
        s_we_s    = s_we_r;
        we_s      = we_r;
`ifdef LOCALBUS_MATRIX_TIMEOUT_EN
        cnt_s     = cnt_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (req) begin
                    s_addr_s  = addr & ~dec_mask_s;
                    s_wdata_s = qin;
                    we_s      = we;
                    busy_s    = 1'b1;
                    if (dec_hit_s) begin
                        state_s = ST_ACCESS;
                        sel_s   = dec_sel_s;
                        s_we_s  = we_vec_s;
`ifdef LOCALBUS_MATRIX_TIMEOUT_EN
                        cnt_s   = {CNT_W{1'b0}};
`endif
                    end else begin
                        state_s = ST_RESP;
                        ready_s = 1'b1;
                        err_s   = 1'b1;
                        qout_s  = {XLEN{1'b0}};
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (slv_rdy_s) begin
                    // s_ready wins over a coincident timeout.
                    state_s = ST_RESP;
                    ready_s = 1'b1;
                    err_s   = 1'b0;
                    qout_s  = (we_r == 3'b000) ? rd_data_s : {XLEN{1'b0}};
                    sel_s   = {NSLV{1'b0}};
                    s_we_s  = {(3*NSLV){1'b0}};
`ifdef LOCALBUS_MATRIX_TIMEOUT_EN
                end else if (cnt_r == CNT_W'(TIMEOUT - 1)) begin
                    state_s = ST_RESP;
                    ready_s = 1'b1;
                    err_s   = 1'b1;
                    qout_s  = {XLEN{1'b0}};
                    sel_s   = {NSLV{1'b0}};
                    s_we_s  = {(3*NSLV){1'b0}};
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
`else
                end else begin
                    state_s = ST_ACCESS;
                end
`endif
            end
            ST_RESP: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
            end
            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
                sel_s   = {NSLV{1'b0}};
                s_we_s  = {(3*NSLV){1'b0}};
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            busy_r    <= 1'b0;
            ready_r   <= 1'b0;
            err_r     <= 1'b0;
            qout_r    <= {XLEN{1'b0}};
            sel_r     <= {NSLV{1'b0}};
            s_addr_r  <= {XLEN{1'b0}};
            s_wdata_r <= {XLEN{1'b0}};
            s_we_r    <= {(3*NSLV){1'b0}};
            we_r      <= 3'b000;
`ifdef LOCALBUS_MATRIX_TIMEOUT_EN
            cnt_r     <= {CNT_W{1'b0}};
`endif
        end else begin
            state_r   <= state_s;
            busy_r    <= busy_s;
            ready_r   <= ready_s;
            err_r     <= err_s;
            qout_r    <= qout_s;
            sel_r     <= sel_s;
            s_addr_r  <= s_addr_s;
            s_wdata_r <= s_wdata_s;
            s_we_r    <= s_we_s;
            we_r      <= we_s;
`ifdef LOCALBUS_MATRIX_TIMEOUT_EN
            cnt_r     <= cnt_s;
`endif
        end
    end

    assign busy    = busy_r;
    assign ready   = ready_r;
    assign err     = err_r;
    assign qout    = qout_r;
    assign s_sel   = sel_r;
    assign s_addr  = s_addr_r;
    assign s_wdata = s_wdata_r;
    assign s_we    = s_we_r;

endmodule
